// File: rtl/rca4_pkg.sv
// rca4_pkg: shared width default and result-word type for the registered ripple-carry adder
package rca4_pkg;
    localparam int RCA4_DEFAULT_WIDTH = 4;
    typedef logic [RCA4_DEFAULT_WIDTH:0] rca4_res_t;
endpackage

// File: rtl/rca4_reg_if.sv
// rca4_reg_if: operand/result bundle for rca4_reg
//   master drives in_valid, a, b, ci; slave drives s, co, out_valid (and ovf when RCA4_OVF_EN is defined)
interface rca4_reg_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             out_valid;
`ifdef RCA4_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, ci, input s, co, out_valid, ovf);
    modport slave  (input in_valid, a, b, ci, output s, co, out_valid, ovf);
`else
    modport master (output in_valid, a, b, ci, input s, co, out_valid);
    modport slave  (input in_valid, a, b, ci, output s, co, out_valid);
`endif
endinterface

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder
//   a, b, ci in; s = a^b^ci, co = majority carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca4_reg.sv
// rca4_reg: registered WIDTH-bit ripple-carry adder, {co,s} = a + b + ci, one cycle latency
//   clk, rst (sync, active-high); bus (slave): in_valid/a/b/ci in, s/co/out_valid out
//   Optional macro RCA4_OVF_EN adds registered two's-complement overflow flag bus.ovf
module rca4_reg
    import rca4_pkg::*;
#(
    parameter int WIDTH = RCA4_DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    rca4_reg_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_d, s_q;
    logic             co_d, co_q;
    logic             vld_d, vld_q;

    assign c[0] = bus.ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    // Results hold between valid operands; out_valid only flags fresh ones.
    always_comb begin
        s_d   = bus.in_valid ? sum : s_q;
        co_d  = bus.in_valid ? c[WIDTH] : co_q;
        vld_d = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            co_q  <= co_d;
            vld_q <= vld_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.out_valid = vld_q;

`ifdef RCA4_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        ovf_d = bus.in_valid ? (c[WIDTH] ^ c[WIDTH-1]) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca4_reg.sv
// tb_rca4_reg: scoreboard bench for rca4_reg (WIDTH=4); define RCA4_OVF_EN to also check ovf
module tb_rca4_reg;
    import rca4_pkg::*;

    typedef struct packed {
        rca4_res_t res;
        logic      ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rca4_reg_if #(.WIDTH(4)) bus ();

    rca4_reg #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic eco, input logic eovf);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        q.push_back({eco, es, eovf});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_co_s"}, 32'({bus.co, bus.s}), 32'd0);
`ifdef RCA4_OVF_EN
        chk({name, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    // Monitor: every presented result must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1 with co_s=%0h, expected no result", {bus.co, bus.s});
            end else begin
                mon_e = q.pop_front();
                chk("result_co_s", 32'({bus.co, bus.s}), 32'(mon_e.res));
`ifdef RCA4_OVF_EN
                chk("result_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    // Hand-computed vectors: a, b, ci, s, co, ovf
    vec_t vecs [9] = '{
        '{4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0},
        '{4'b1000, 4'b0111, 1'b0, 4'b1111, 1'b0, 1'b0},
        '{4'b1100, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0},
        '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0},
        '{4'b0001, 4'b0111, 1'b1, 4'b1001, 1'b0, 1'b1},
        '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0},
        '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0},
        '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1},
        '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.ci       = 1'b0;
        rst          = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_zero("post_reset_idle");
        end
        @(posedge clk);
        #1;

        foreach (vecs[i])
            issue(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ovf);

        // Single pulse then idle: result must hold while out_valid drops.
        issue(4'b1100, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        chk("pulse_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd0);
            chk("hold_co_s", 32'({bus.co, bus.s}), 32'h11);
        end
        @(posedge clk);
        #1;

        // Reset mid-stream: operand offered during reset is discarded.
        issue(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 4'b1111;
        bus.b        = 4'b1111;
        bus.ci       = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        @(posedge clk);
        #1;

`ifdef RCA4_OVF_EN
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    int r;
                    int sr;
                    r  = x + y + c;
                    sr = (x > 7 ? x - 16 : x) + (y > 7 ? y - 16 : y) + c;
                    issue(4'(x), 4'(y), 1'(c), 4'(r), r > 15, (sr > 7) || (sr < -8));
                end
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
